irq_encode16: RTL and testbench
===============================

// Module: irq_encode16
// PURPOSE
//   Registered 16-to-4 priority encoder: the return path for the 4-to-16 active-low select decoders.
//   Samples 16 active-low request lines gated by an active-low enable and latches them as pending.
//   Presents the highest-priority unmasked pending index as a 4-bit code under a valid/ack handshake.
//   Sits between the decoded interrupt/select sources and the CPU-side interrupt vector logic.
// PARAMETERS
//   EDGE       1  1 = request latched on high->low edge of reqn; 0 = level (pend follows sampled lines)
//   PRIO_HIGH  0  0 = lowest index wins (line 0 highest); 1 = highest index wins (line 15 highest)
// PORTS
//   clk     in   1   system clock, all state on rising edge
//   resetl  in   1   asynchronous active-low reset
//   reqn    in   16  request lines, active low, bit i = source i
//   gn      in   1   active-low sample enable; high blocks new sampling
//   mask    in   16  1 = source excluded from selection (pending bit still kept)
//   ack     in   1   consumer accepts presented code; ignored unless valid=1
//   code    out  4   encoded index of presented source, registered
//   valid   out  1   code is valid, registered
//   anyn    out  1   active low: some unmasked pending bit set (combinational from pend, mask)
// BEHAVIOUR
//   Reset (resetl=0, async): req_s, req_d, pend = 0; code = 0; valid = 0; state = IDLE; anyn = 1.
//   Reset mid-handshake: valid drops immediately, all pending lost; no code re-presented after release.
//   Stage 1 (every edge): req_s <= ~reqn & {16{~gn}}; req_d <= req_s.
//   Pend, EDGE=1: pend[i] set when req_s[i] & ~req_d[i]; cleared when ack accepted for code==i.
//     Set and clear of same bit in same cycle: set wins (new edge not lost).
//   Pend, EDGE=0: pend <= req_s each edge; ack does not touch pend.
//   gn=1: req_s forced 0; EDGE=1 keeps existing pend; EDGE=0 pend empties next edge.
//   Selection: sel = pend & ~mask; index chosen per PRIO_HIGH; evaluated only in IDLE.
//   FSM:
//     IDLE:    |sel -> code <= index, valid <= 1, go PRESENT; else stay, valid = 0.
//     PRESENT: code/valid held stable regardless of reqn, mask, gn, pend changes.
//              ack=1 -> valid <= 0, clear pend[code] (EDGE=1), go GAP; ack=0 -> stay.
//     GAP:     one cycle, valid = 0, lets pend settle -> IDLE.
//   Latency: reqn first sampled low at edge E0 -> req_s at E0, pend at E1, valid/code at E2.
//   Ack held high continuously: valid pattern 1,0,0 per code (one code per 3 clocks max).
//   Code presented stays valid even if its source is masked or released (EDGE=0) while PRESENT.
//   Masked pending bits never selected; unmasking later presents them from IDLE.
//   sel == 0 in IDLE: code keeps last value, valid stays 0.
//   code width fixed 4 bits; no encoding of "none" (valid=0 denotes none).
// TESTING
//   1 Reset: resetl=0 mid-run -> valid=0, code=0, anyn=1 at once; release with reqn=FFFF -> valid stays 0.
//   2 EDGE=1, gn=0, reqn[5] low 1 clk at E0 -> valid=1, code=5 at E2; ack=0 10 clks -> held; ack 1 clk -> valid=0, anyn=1.
//   3 reqn[3],reqn[9] low same clk, PRIO_HIGH=0 -> code 3, ack, GAP, code 9; PRIO_HIGH=1 -> 9 then 3.
//   4 mask[3]=1 with 3,9 pending -> code 9 only; after ack clear mask[3] -> code 3 presented 2 clks later.
//   5 gn=1 during reqn[7] pulse -> never valid; new reqn[2] edge in same cycle as ack of code 2 -> code 2 re-presented.
//   6 EDGE=0, reqn[4] held low -> code 4; ack while still low -> code 4 re-presented after GAP; release -> no further valid.

Source files
------------

// File: rtl/irq_encode16.sv
// Registered 16-to-4 priority encoder with pending latch and valid/ack handshake.
// One lane per request line holds the synchroniser, edge detect and pending bit.

module irq_encode16_lane #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic resetl,
  input  logic reqn,
  input  logic gn,
  input  logic clr,
  output logic pend
);
  logic req_s, req_d;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      req_s <= 1'b0;
      req_d <= 1'b0;
      pend  <= 1'b0;
    end else begin
      req_s <= ~reqn & ~gn;
      req_d <= req_s;
      // a fresh edge in the same cycle as the ack clear must survive
      if (EDGE) pend <= (req_s & ~req_d) | (pend & ~clr);
      else      pend <= req_s;
    end
  end
endmodule

module irq_encode16 #(
  parameter bit EDGE      = 1'b1,
  parameter bit PRIO_HIGH = 1'b0
) (
  input  logic        clk,
  input  logic        resetl,
  input  logic [15:0] reqn,
  input  logic        gn,
  input  logic [15:0] mask,
  input  logic        ack,
  output logic [3:0]  code,
  output logic        valid,
  output logic        anyn
);
  localparam int NUM_LANES = 16;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

  state_t               state, state_nxt;
  logic [NUM_LANES-1:0] pend, sel, clr;
  logic [IDX_W-1:0]     idx, code_nxt;
  logic                 valid_nxt, ack_take;

  assign ack_take = (state == PRESENT) & ack;
  assign sel      = pend & ~mask;
  assign anyn     = ~|sel;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign clr[i] = ack_take & (code == IDX_W'(i));
    irq_encode16_lane #(.EDGE(EDGE)) u_lane (
      .clk    (clk),
      .resetl (resetl),
      .reqn   (reqn[i]),
      .gn     (gn),
      .clr    (clr[i]),
      .pend   (pend[i])
    );
  end

  // last match in scan order wins
  always_comb begin
    idx = '0;
    if (PRIO_HIGH) begin
      for (int i = 0; i < NUM_LANES; i++)
        if (sel[i]) idx = IDX_W'(i);
    end else begin
      for (int i = NUM_LANES-1; i >= 0; i--)
        if (sel[i]) idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    valid_nxt = valid;
    case (state)
      IDLE: begin
        if (|sel) begin
          code_nxt  = idx;
          valid_nxt = 1'b1;
          state_nxt = PRESENT;
        end else begin
          valid_nxt = 1'b0;
        end
      end
      PRESENT: begin
        if (ack) begin
          valid_nxt = 1'b0;
          state_nxt = GAP;
        end
      end
      GAP: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state <= IDLE;
      code  <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      code  <= code_nxt;
      valid <= valid_nxt;
    end
  end
endmodule

// File: tb/tb_irq_encode16.sv
// Directed bench for irq_encode16: three instances (edge/low-prio, edge/high-prio,
// level/low-prio) share one stimulus stream; each step checks the instance of interest.

module tb_irq_encode16;
  logic        clk = 1'b0;
  logic        resetl = 1'b0;
  logic [15:0] reqn = 16'hFFFF;
  logic        gn = 1'b0;
  logic [15:0] mask = 16'h0000;
  logic        ack = 1'b0;

  logic [3:0]  code0, code1, code2;
  logic        valid0, valid1, valid2;
  logic        anyn0, anyn1, anyn2;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  irq_encode16 #(.EDGE(1'b1), .PRIO_HIGH(1'b0)) u0 (
    .clk(clk), .resetl(resetl), .reqn(reqn), .gn(gn), .mask(mask), .ack(ack),
    .code(code0), .valid(valid0), .anyn(anyn0));
  irq_encode16 #(.EDGE(1'b1), .PRIO_HIGH(1'b1)) u1 (
    .clk(clk), .resetl(resetl), .reqn(reqn), .gn(gn), .mask(mask), .ack(ack),
    .code(code1), .valid(valid1), .anyn(anyn1));
  irq_encode16 #(.EDGE(1'b0), .PRIO_HIGH(1'b0)) u2 (
    .clk(clk), .resetl(resetl), .reqn(reqn), .gn(gn), .mask(mask), .ack(ack),
    .code(code2), .valid(valid2), .anyn(anyn2));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reqn = 16'hFFFF; gn = 1'b0; mask = 16'h0000; ack = 1'b0;
    resetl = 1'b0;
    tick(2);
    resetl = 1'b1;
    tick(1);
  endtask

  initial begin
    // reset state
    do_reset();
    chk("rst_valid", 16'(valid0), 16'h0);
    chk("rst_code",  16'(code0),  16'h0);
    chk("rst_anyn",  16'(anyn0),  16'h1);

    // single pulse on line 5: latency and hold
    reqn = ~16'h0020; tick(1);
    reqn = 16'hFFFF;
    chk("t2_e0_valid", 16'(valid0), 16'h0);
    tick(1);
    chk("t2_e1_valid", 16'(valid0), 16'h0);
    chk("t2_e1_anyn",  16'(anyn0),  16'h0);
    tick(1);
    chk("t2_e2_valid", 16'(valid0), 16'h1);
    chk("t2_e2_code",  16'(code0),  16'h5);
    reqn = 16'h0000; mask = 16'hFFFF; tick(10);
    chk("t2_hold_valid", 16'(valid0), 16'h1);
    chk("t2_hold_code",  16'(code0),  16'h5);
    do_reset();
    reqn = ~16'h0020; tick(1); reqn = 16'hFFFF; tick(2);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("t2_ack_valid", 16'(valid0), 16'h0);
    chk("t2_ack_anyn",  16'(anyn0),  16'h1);
    tick(3);
    chk("t2_no_repeat", 16'(valid0), 16'h0);

    // lines 3 and 9 together: priority order both ways
    do_reset();
    reqn = ~16'h0208; tick(1); reqn = 16'hFFFF; tick(2);
    chk("t3_lo_first", 16'(code0), 16'h3);
    chk("t3_hi_first", 16'(code1), 16'h9);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("t3_gap_valid", 16'(valid0), 16'h0);
    tick(1);
    chk("t3_idle_valid", 16'(valid0), 16'h0);
    tick(1);
    chk("t3_lo_second_v", 16'(valid0), 16'h1);
    chk("t3_lo_second",   16'(code0),  16'h9);
    chk("t3_hi_second",   16'(code1),  16'h3);

    // ack held high: one code per three clocks
    do_reset();
    reqn = ~16'h0208; tick(1); reqn = 16'hFFFF; tick(2);
    ack = 1'b1;
    chk("t3_burst_v0", 16'(valid0), 16'h1);
    tick(1);
    chk("t3_burst_v1", 16'(valid0), 16'h0);
    tick(1);
    chk("t3_burst_v2", 16'(valid0), 16'h0);
    tick(1);
    chk("t3_burst_v3", 16'(valid0), 16'h1);
    chk("t3_burst_c3", 16'(code0),  16'h9);
    tick(1);
    ack = 1'b0;

    // masked line 3 skipped until unmasked
    do_reset();
    mask = 16'h0008;
    reqn = ~16'h0208; tick(1); reqn = 16'hFFFF; tick(2);
    chk("t4_masked_code", 16'(code0), 16'h9);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("t4_anyn_masked", 16'(anyn0), 16'h1);
    mask = 16'h0000;
    #1;
    chk("t4_anyn_unmask", 16'(anyn0), 16'h0);
    tick(1);
    chk("t4_idle_valid", 16'(valid0), 16'h0);
    tick(1);
    chk("t4_unmask_v", 16'(valid0), 16'h1);
    chk("t4_unmask_c", 16'(code0),  16'h3);

    // gn blocks sampling; new edge coincident with ack is kept
    do_reset();
    gn = 1'b1; reqn = ~16'h0080; tick(1); reqn = 16'hFFFF; tick(1); gn = 1'b0; tick(3);
    chk("t5_gn_valid", 16'(valid0), 16'h0);
    chk("t5_gn_anyn",  16'(anyn0),  16'h1);
    reqn = ~16'h0004; tick(1); reqn = 16'hFFFF; tick(2);
    chk("t5_c2_first", 16'(code0), 16'h2);
    reqn = ~16'h0004; tick(1);
    reqn = 16'hFFFF; ack = 1'b1; tick(1); ack = 1'b0;
    chk("t5_gap_valid", 16'(valid0), 16'h0);
    chk("t5_kept_anyn", 16'(anyn0),  16'h0);
    tick(2);
    chk("t5_re_valid", 16'(valid0), 16'h1);
    chk("t5_re_code",  16'(code0),  16'h2);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("t5_done_anyn", 16'(anyn0), 16'h1);

    // level mode on line 4
    do_reset();
    reqn = ~16'h0010; tick(3);
    chk("t6_v", 16'(valid2), 16'h1);
    chk("t6_c", 16'(code2),  16'h4);
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("t6_gap_valid", 16'(valid2), 16'h0);
    tick(2);
    chk("t6_re_valid", 16'(valid2), 16'h1);
    chk("t6_re_code",  16'(code2),  16'h4);
    reqn = 16'hFFFF; tick(2);
    chk("t6_rel_anyn",  16'(anyn2),  16'h1);
    chk("t6_rel_valid", 16'(valid2), 16'h1);
    ack = 1'b1; tick(1); ack = 1'b0; tick(3);
    chk("t6_after_valid", 16'(valid2), 16'h0);

    // level mode: gn high empties pend
    reqn = ~16'h0010; tick(2);
    chk("t6_gn_pre_anyn", 16'(anyn2), 16'h0);
    gn = 1'b1; tick(2);
    chk("t6_gn_anyn", 16'(anyn2), 16'h1);
    gn = 1'b0; reqn = 16'hFFFF;

    // async reset mid-handshake
    do_reset();
    reqn = ~16'h0040; tick(1); reqn = 16'hFFFF; tick(2);
    chk("t1_pre_valid", 16'(valid0), 16'h1);
    #2 resetl = 1'b0;
    #1;
    chk("t1_async_valid", 16'(valid0), 16'h0);
    chk("t1_async_code",  16'(code0),  16'h0);
    chk("t1_async_anyn",  16'(anyn0),  16'h1);
    tick(1);
    resetl = 1'b1;
    tick(4);
    chk("t1_post_valid", 16'(valid0), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
